// File: rtl/vga_pal_dac_pkg.sv
// Shared constants and FSM encodings for the VGA palette/DAC block.
// Imported by the DAC RAM and the top level.
package vga_pal_dac_pkg;
  localparam int DAC_DEPTH = 256;
  localparam int DAC_WIDTH = 18;
  localparam int DAC_AW    = $clog2(DAC_DEPTH);

  typedef enum logic [1:0] {
    WR_R = 2'd0,
    WR_G = 2'd1,
    WR_B = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_R = 2'd0,
    RD_G = 2'd1,
    RD_B = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb_t;
endpackage

// File: rtl/vga_dac_ram.sv
// Two-port 256x18 colour RAM, synchronous read on both ports.
// Port a is the pixel read port; port b is the CPU read/write port.
module vga_dac_ram
  import vga_pal_dac_pkg::*;
(
  input  logic                 clk,
  input  logic                 a_en,
  input  logic [DAC_AW-1:0]    a_addr,
  output logic [DAC_WIDTH-1:0] a_dat,
  input  logic                 b_we,
  input  logic                 b_re,
  input  logic [DAC_AW-1:0]    b_addr,
  input  logic [DAC_WIDTH-1:0] b_wdat,
  output logic [DAC_WIDTH-1:0] b_rdat
);
  logic [DAC_WIDTH-1:0] mem [DAC_DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) a_dat <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdat;
    if (b_re) b_rdat <= mem[b_addr];
  end
endmodule

// File: rtl/vga_pal_dac.sv
// Attribute palette, DAC colour RAM and 3-stage pixel pipeline,
// with the CPU index/data write and read state machines.
module vga_pal_dac
  import vga_pal_dac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] attr,
  input  logic       horiz_sync_i,
  input  logic       video_on_h_i,
  input  logic [7:0] pel_mask,
  input  logic       att_pal_we,
  input  logic [3:0] att_pal_idx,
  input  logic [5:0] att_pal_dat,
  output logic [5:0] att_pal_rd_dat,
  input  logic [7:0] cpu_dat_i,
  input  logic       dac_write_index_we,
  input  logic       dac_read_index_we,
  input  logic       dac_data_we,
  input  logic       dac_data_rd,
  output logic [5:0] dac_dat_o,
  output logic [1:0] dac_state_o,
  output logic [5:0] vga_red_o,
  output logic [5:0] vga_green_o,
  output logic [5:0] vga_blue_o,
  output logic       horiz_sync_o,
  output logic       video_on_o
);
  logic [5:0] att_pal [16];
  logic [5:0] pal;
  logic [1:0] hs_d;
  logic [1:0] vo_d;
  logic [DAC_WIDTH-1:0] pix;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic [7:0] write_index;
  logic [7:0] read_index;
  logic [5:0] red;
  logic [5:0] green;
  logic       lat_r, lat_g, ram_we;
  logic       rd_wrap, pf_req, pf_issue;
  logic       pf_pend, pf_valid;
  rgb_t       pf_buf;
  logic [DAC_WIDTH-1:0] b_rdat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) att_pal[i] <= 6'(i);
    end else if (att_pal_we) begin
      att_pal[att_pal_idx] <= att_pal_dat;
    end
  end

  assign att_pal_rd_dat = att_pal[att_pal_idx];

  // The RAM output register is the middle pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal          <= '0;
      hs_d         <= '0;
      vo_d         <= '0;
      horiz_sync_o <= 1'b0;
      video_on_o   <= 1'b0;
      vga_red_o    <= '0;
      vga_green_o  <= '0;
      vga_blue_o   <= '0;
    end else if (enable) begin
      pal          <= att_pal[attr];
      hs_d         <= {hs_d[0], horiz_sync_i};
      vo_d         <= {vo_d[0], video_on_h_i};
      horiz_sync_o <= hs_d[1];
      video_on_o   <= vo_d[1];
      {vga_red_o, vga_green_o, vga_blue_o} <= vo_d[1] ? pix : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state <= WR_R;
    else     wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    priority case (1'b1)
      dac_write_index_we: wr_next = WR_R;
      dac_data_we: begin
        unique case (wr_state)
          WR_R:    wr_next = WR_G;
          WR_G:    wr_next = WR_B;
          default: wr_next = WR_R;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    lat_r  = 1'b0;
    lat_g  = 1'b0;
    ram_we = 1'b0;
    if (dac_data_we && !dac_write_index_we) begin
      lat_r  = (wr_state == WR_R);
      lat_g  = (wr_state == WR_G);
      ram_we = (wr_state == WR_B);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_index <= '0;
      red         <= '0;
      green       <= '0;
    end else begin
      if (dac_write_index_we) write_index <= cpu_dat_i;
      else if (ram_we)        write_index <= write_index + 1'b1;
      if (lat_r) red   <= cpu_dat_i[5:0];
      if (lat_g) green <= cpu_dat_i[5:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= RD_R;
    else     rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    priority case (1'b1)
      dac_read_index_we: rd_next = RD_R;
      dac_data_rd: begin
        unique case (rd_state)
          RD_R:    rd_next = RD_G;
          RD_G:    rd_next = RD_B;
          default: rd_next = RD_R;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_wrap = dac_data_rd && !dac_read_index_we && (rd_state == RD_B);
    unique case (rd_state)
      RD_R:    dac_dat_o = pf_buf.r;
      RD_G:    dac_dat_o = pf_buf.g;
      default: dac_dat_o = pf_buf.b;
    endcase
  end

  assign pf_req   = dac_read_index_we | rd_wrap;
  // The shared CPU port gives writes priority; a prefetch waits a cycle.
  assign pf_issue = pf_pend & ~ram_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_index <= '0;
      pf_pend    <= 1'b0;
      pf_valid   <= 1'b0;
      pf_buf     <= '0;
    end else begin
      if (dac_read_index_we) read_index <= cpu_dat_i;
      else if (rd_wrap)      read_index <= read_index + 1'b1;
      pf_pend  <= pf_req | (pf_pend & ~pf_issue);
      pf_valid <= pf_issue;
      if (pf_valid) pf_buf <= b_rdat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     dac_state_o <= 2'b00;
    else if (dac_read_index_we)  dac_state_o <= 2'b11;
    else if (dac_write_index_we) dac_state_o <= 2'b00;
  end

  vga_dac_ram u_ram (
    .clk    (clk),
    .a_en   (enable),
    .a_addr ({2'b00, pal} & pel_mask),
    .a_dat  (pix),
    .b_we   (ram_we),
    .b_re   (pf_issue),
    .b_addr (ram_we ? write_index : read_index),
    .b_wdat ({red, green, cpu_dat_i[5:0]}),
    .b_rdat (b_rdat)
  );
endmodule

// File: doc/vga_pal_dac.md
VGA_PAL_DAC -- requirements
Module: vga_pal_dac

Interface
REQ-001 Parameters: none; all widths fixed by this document.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 enable  in  1  pixel-pipeline advance qualifier.
REQ-005 attr  in  4  pixel attribute from planar/text stage.
REQ-006 horiz_sync_i, video_on_h_i  in  1 each  timing aligned with attr.
REQ-007 pel_mask  in  8  DAC index mask.
REQ-008 att_pal_we  in  1; att_pal_idx  in  4; att_pal_dat  in  6  attribute-palette write port.
REQ-009 att_pal_rd_dat  out  6  attribute palette entry at att_pal_idx.
REQ-010 cpu_dat_i  in  8  CPU data for DAC index/data writes.
REQ-011 dac_write_index_we, dac_read_index_we, dac_data_we, dac_data_rd  in  1 each  single-cycle CPU strobes.
REQ-012 dac_dat_o  out  6  current DAC read component; dac_state_o  out  2  last index access.
REQ-013 vga_red_o, vga_green_o, vga_blue_o  out  6 each; horiz_sync_o, video_on_o  out  1 each.

Function
REQ-014 Pixel path stage 1: pal <= att_pal[attr]; stage 2: RAM read at ({2'b00,pal} & pel_mask); stage 3: RGB register; all stages advance only when enable=1.
REQ-015 With enable held high, attr sampled at edge k SHALL appear on RGB outputs after edge k+3.
REQ-016 horiz_sync_i and video_on_h_i SHALL be delayed by the same 3 enabled cycles.
REQ-017 RGB outputs SHALL be 0 whenever the delayed video_on is 0.
REQ-018 Attribute palette: 16x6 registers, written on att_pal_we at clk edge; att_pal_rd_dat combinational.
REQ-019 DAC RAM: 256x18 {R,G,B}, pixel read port and CPU read/write port independent.
REQ-020 Write FSM states WR_R, WR_G, WR_B; dac_write_index_we loads write_index=cpu_dat_i, state WR_R, dac_state_o=2'b00.
REQ-021 dac_data_we in WR_R latches red, in WR_G latches green, in WR_B writes {red,green,cpu_dat_i[5:0]} to RAM[write_index], increments write_index, and returns to WR_R.
REQ-022 Read FSM states RD_R, RD_G, RD_B; dac_read_index_we loads read_index=cpu_dat_i, state RD_R, dac_state_o=2'b11, schedules a prefetch.
REQ-023 Prefetch result SHALL be held in an 18-bit buffer; dac_dat_o selects R/G/B per read state, valid 2 cycles after the prefetch request.
REQ-024 dac_data_rd advances R->G->B; from RD_B it increments read_index, returns to RD_R, and schedules a new prefetch.
REQ-025 write_index and read_index SHALL wrap 255->0.
REQ-026 Index write coincident with a data strobe of the same FSM: the index write wins, the data strobe is ignored.
REQ-027 A CPU RAM write and a pending prefetch in the same cycle: the write wins, and the prefetch stays pending and issues next free cycle.
REQ-028 CPU paths SHALL ignore enable.
REQ-029 A dac_data_rd arriving before dac_dat_o is valid is a usage error, and the result is undefined.

Reset
REQ-030 On rst: all outputs 0, pipeline registers 0, FSMs WR_R/RD_R, indices 0, dac_state_o=2'b00, prefetch pending cleared.
REQ-031 On rst: att_pal[i] = {2'b00,i}. DAC RAM contents are not reset.
REQ-032 Reset asserted mid-sequence abandons partial R/G latches with no RAM write.

Structure
REQ-033 A shared package holds FSM state encodings and the DAC depth/width constants (256, 18).
REQ-034 Sub-module vga_dac_ram is a two-port 256x18 RAM with synchronous read.

Verification
REQ-035 Write index 0x10, data 0x3F,0x00,0x15 -> RAM[0x10]=0x3F/0x00/0x15, write_index=0x11.
REQ-036 Read index 0x10, wait 2 cycles, three dac_data_rd -> dac_dat_o 0x3F,0x00,0x15, read_index=0x11.
REQ-037 att_pal[5]=0x10, pel_mask=0xFF, attr=5, video_on=1 -> RGB of RAM[0x10] exactly 3 enabled cycles later; sync delayed 3.
REQ-038 video_on_h_i=0 with valid attr -> RGB 0 after 3 cycles; enable toggling stretches latency in enabled cycles only.
REQ-039 Write index 0xFF, six data writes -> entries 0xFF and 0x00 written (wrap).
REQ-040 Assert rst after red write, then write G,B -> no RAM write; att_pal_rd_dat at idx 7 = 0x07.
